// File: rtl/div_arbiter_if.sv
// rtl/div_arbiter_if.sv - requester and divider bus shared by div_arbiter and its neighbours
interface div_arbiter_if #(
  parameter int SIZE = 32,
  parameter int N    = 4
);
  logic [N-1:0]      req_valid;
  logic [N*SIZE-1:0] req_num;
  logic [N*SIZE-1:0] req_den;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [SIZE-1:0]   rsp_cociente;
  logic [SIZE-1:0]   rsp_resto;
  logic              rsp_err;
  logic              div_start;
  logic [SIZE-1:0]   div_numerador;
  logic [SIZE-1:0]   div_denominador;
  logic [SIZE-1:0]   div_cociente;
  logic [SIZE-1:0]   div_resto;
  logic              div_done;

  modport slave (
    input  req_valid, req_num, req_den, div_cociente, div_resto, div_done,
    output req_ready, rsp_valid, rsp_cociente, rsp_resto, rsp_err,
           div_start, div_numerador, div_denominador
  );

  modport master (
    output req_valid, req_num, req_den, div_cociente, div_resto, div_done,
    input  req_ready, rsp_valid, rsp_cociente, rsp_resto, rsp_err,
           div_start, div_numerador, div_denominador
  );
endinterface

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one iterative divider among N requesters
// Optional feature: DIV_ARB_ZERO_BYPASS_EN answers zero denominators without using the divider.
module div_arbiter #(
  parameter int SIZE    = 32,
  parameter int N       = 4,
  parameter int TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  div_arbiter_if.slave s_bus
);
  localparam int              PW       = (N > 1) ? $clog2(N) : 1;
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);
  localparam logic [N-1:0]    ONE      = N'(1);
  localparam logic [PW:0]     N_EXT    = (PW+1)'(N);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;
  logic            r_done_prev;
  logic [SIZE-1:0] r_num;
  logic [SIZE-1:0] r_den;
  logic [SIZE-1:0] r_quo;
  logic [SIZE-1:0] r_rem;
  logic            r_err;

  logic [N-1:0]    w_rot;
  logic            w_found;
  logic [PW-1:0]   w_off;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_gnt;
  logic [SIZE-1:0] w_num;
  logic [SIZE-1:0] w_den;
  logic            w_done_edge;
  logic            w_timeout;
  logic            w_bypass;

  // Rotate requests so bit 0 is the current highest-priority requester.
  assign w_rot = (s_bus.req_valid >> r_ptr) | (s_bus.req_valid << (N - int'(r_ptr)));

  always_comb begin
    w_found = |w_rot;
    w_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = PW'(i);
    end
  end

  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_gnt = (w_sum >= N_EXT) ? PW'(w_sum - N_EXT) : w_sum[PW-1:0];

  always_comb begin
    w_num = '0;
    w_den = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == PW'(i)) begin
        w_num = s_bus.req_num[i*SIZE +: SIZE];
        w_den = s_bus.req_den[i*SIZE +: SIZE];
      end
    end
  end

`ifdef DIV_ARB_ZERO_BYPASS_EN
  assign w_bypass = (w_den == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // A done level left over from the previous operation never counts; only a 0->1 edge does.
  assign w_done_edge = s_bus.div_done & ~r_done_prev;
  assign w_timeout   = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = w_bypass ? RESP : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_done_edge || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_bus.req_ready = '0;
    s_bus.rsp_valid = '0;
    s_bus.div_start = 1'b0;
    case (r_state)
      IDLE:    if (w_found && rst_n) s_bus.req_ready = ONE << w_gnt;
      ISSUE:   s_bus.div_start = 1'b1;
      RESP:    s_bus.rsp_valid = ONE << r_owner;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_done_prev <= 1'b0;
      r_num       <= '0;
      r_den       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_done_prev <= s_bus.div_done;
      case (r_state)
        IDLE: if (w_found) begin
          r_owner <= w_gnt;
          r_num   <= w_num;
          r_den   <= w_den;
          if (w_bypass) begin
            r_quo <= '1;
            r_rem <= w_num;
            r_err <= 1'b1;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (w_done_edge) begin
            r_quo <= s_bus.div_cociente;
            r_rem <= s_bus.div_resto;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_quo <= '0;
            r_rem <= '0;
            r_err <= 1'b1;
          end
        end
        RESP: r_ptr <= (r_owner == PW'(N - 1)) ? '0 : r_owner + 1'b1;
        default: ;
      endcase
    end
  end

  assign s_bus.rsp_cociente    = r_quo;
  assign s_bus.rsp_resto       = r_rem;
  assign s_bus.rsp_err         = r_err;
  assign s_bus.div_numerador   = r_num;
  assign s_bus.div_denominador = r_den;
endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - randomized self-checking bench for div_arbiter with a timeline reference model
module tb_div_arbiter;
  localparam int SIZE    = 32;
  localparam int N       = 4;
  localparam int TIMEOUT = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  div_arbiter_if #(.SIZE(SIZE), .N(N)) bus ();

  div_arbiter #(.SIZE(SIZE), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Requester queues: each requester presents its front op until accepted.
  logic [SIZE-1:0] qn [N][64];
  logic [SIZE-1:0] qd [N][64];
  int qh [N];
  int qt [N];

  task automatic push(input int i, input logic [SIZE-1:0] n, input logic [SIZE-1:0] d);
    qn[i][qt[i] % 64] = n;
    qd[i][qt[i] % 64] = d;
    qt[i]++;
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (qh[i] != qt[i]) p = 1'b1;
    return p;
  endfunction

  initial begin
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
    bus.req_valid = '0;
    bus.req_num   = '0;
    bus.req_den   = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_ready & {N{rst_n}};
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) qh[i]++;
        if (qh[i] != qt[i]) begin
          bus.req_valid[i] = 1'b1;
          bus.req_num[i*SIZE +: SIZE] = qn[i][qh[i] % 64];
          bus.req_den[i*SIZE +: SIZE] = qd[i][qh[i] % 64];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_num[i*SIZE +: SIZE] = $urandom;
          bus.req_den[i*SIZE +: SIZE] = $urandom;
        end
      end
    end
  end

  // Divider stub: done stays high until the next start, then drops (optionally one cycle late).
  int hang_mode  = 0;
  int fix_lat    = 5;
  bit stale_rand = 1'b0;

  initial begin
    logic st;
    logic [SIZE-1:0] n, d, sn, sd;
    int fall_c, rise_c, extra;
    fall_c = -1; rise_c = -1; sn = '0; sd = '0;
    bus.div_done     = 1'b0;
    bus.div_cociente = '0;
    bus.div_resto    = '0;
    forever begin
      @(negedge clk);
      st = bus.div_start;
      n  = bus.div_numerador;
      d  = bus.div_denominador;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        fall_c = -1; rise_c = -1; bus.div_done = 1'b0;
      end else if (st) begin
        extra  = stale_rand ? int'($urandom_range(0, 1)) : 0;
        fall_c = cyc + extra;
        rise_c = fall_c + ((fix_lat != 0) ? fix_lat : int'($urandom_range(1, 10)));
        if (hang_mode == 1 || (hang_mode == 2 && $urandom_range(0, 49) == 0)) rise_c = -1;
        sn = n; sd = d;
      end
      if (cyc == fall_c) bus.div_done = 1'b0;
      if (cyc == rise_c) begin
        bus.div_done     = 1'b1;
        bus.div_cociente = (sd == 0) ? '1 : sn / sd;
        bus.div_resto    = (sd == 0) ? sn : sn % sd;
      end
    end
  end

  // Event logs of DUT activity, used by the directed literal checks.
  int acc_n = 0, st_n = 0, rsp_n = 0;
  int acc_idx [1024];
  int acc_cyc [1024];
  int st_cyc  [1024];
  int rsp_idx [1024];
  int rsp_cyc [1024];
  logic [SIZE-1:0] rsp_q [1024];
  logic [SIZE-1:0] rsp_r [1024];
  logic            rsp_e [1024];

  // Reference model: timeline of one transaction derived from the accept cycle.
  bit              m_busy = 1'b0;
  bit              m_bypass, m_resolved, m_prev;
  int              m_ptr = 0, m_owner, m_t, m_rcyc;
  logic [SIZE-1:0] m_num, m_den, m_eq, m_er;
  logic            m_ee;

  initial begin
    logic [N-1:0] exp_ready, exp_rsp;
    logic         exp_start;
    bit           found;
    int           g;
    m_prev = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ready[i]) begin
          acc_idx[acc_n % 1024] = i; acc_cyc[acc_n % 1024] = cyc; acc_n++;
        end
        if (bus.rsp_valid[i]) begin
          rsp_idx[rsp_n % 1024] = i; rsp_cyc[rsp_n % 1024] = cyc;
          rsp_q[rsp_n % 1024] = bus.rsp_cociente; rsp_r[rsp_n % 1024] = bus.rsp_resto;
          rsp_e[rsp_n % 1024] = bus.rsp_err; rsp_n++;
        end
      end
      if (bus.div_start) begin st_cyc[st_n % 1024] = cyc; st_n++; end

      if (!rst_n) begin
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_div_start", bus.div_start, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_cociente", bus.rsp_cociente, 0);
        chk("rst_resto", bus.rsp_resto, 0);
        chk("rst_div_num", bus.div_numerador, 0);
        chk("rst_div_den", bus.div_denominador, 0);
        m_busy = 1'b0; m_ptr = 0; m_prev = 1'b0;
      end else begin
        exp_ready = '0;
        if (!m_busy && bus.req_valid != 0) begin
          found = 1'b0; g = 0;
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!found && bus.req_valid[j]) begin found = 1'b1; g = j; end
          end
          exp_ready[g] = 1'b1;
          m_busy = 1'b1; m_t = cyc; m_owner = g; m_resolved = 1'b0;
          m_num = bus.req_num[g*SIZE +: SIZE];
          m_den = bus.req_den[g*SIZE +: SIZE];
`ifdef DIV_ARB_ZERO_BYPASS_EN
          m_bypass = (m_den == 0);
`else
          m_bypass = 1'b0;
`endif
          if (m_bypass) begin
            m_resolved = 1'b1; m_rcyc = cyc + 1; m_eq = '1; m_er = m_num; m_ee = 1'b1;
          end
        end
        chk("req_ready", bus.req_ready, exp_ready);

        exp_start = m_busy && !m_bypass && (cyc == m_t + 1);
        chk("div_start", bus.div_start, exp_start);

        if (m_busy && !m_resolved && cyc >= m_t + 2) begin
          if (bus.div_done && !m_prev) begin
            m_resolved = 1'b1; m_rcyc = cyc + 1; m_ee = 1'b0;
            m_eq = (m_den == 0) ? '1 : m_num / m_den;
            m_er = (m_den == 0) ? m_num : m_num % m_den;
          end else if (cyc == m_t + 2 + TIMEOUT - 1) begin
            m_resolved = 1'b1; m_rcyc = cyc + 1; m_eq = '0; m_er = '0; m_ee = 1'b1;
          end
        end

        if (m_busy && cyc > m_t) begin
          chk("div_numerador", bus.div_numerador, m_num);
          chk("div_denominador", bus.div_denominador, m_den);
        end

        exp_rsp = '0;
        if (m_busy && m_resolved && cyc == m_rcyc) exp_rsp[m_owner] = 1'b1;
        chk("rsp_valid", bus.rsp_valid, exp_rsp);
        if (exp_rsp != 0) begin
          chk("rsp_cociente", bus.rsp_cociente, m_eq);
          chk("rsp_resto", bus.rsp_resto, m_er);
          chk("rsp_err", bus.rsp_err, m_ee);
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % N;
        end
        m_prev = bus.div_done;
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int b = 0;
    repeat (2) @(negedge clk);
    while ((pending() || m_busy) && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk(name, (b < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_reset(input logic v);
    @(posedge clk);
    #2;
    rst_n = v;
  endtask

  initial begin
    int ba, bs, br, b;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_req_ready", bus.req_ready, 0);
    chk("init_div_start", bus.div_start, 0);
    chk("init_rsp_valid", bus.rsp_valid, 0);
    set_reset(1'b1);

    // Single request on requester 2: 100/7.
    ba = acc_n; bs = st_n; br = rsp_n;
    push(2, 100, 7);
    wait_idle("t1_drain", 100);
    chk("t1_nacc", acc_n - ba, 1);
    chk("t1_gnt", acc_idx[ba], 2);
    chk("t1_start_lat", st_cyc[bs] - acc_cyc[ba], 1);
    chk("t1_rsp_idx", rsp_idx[br], 2);
    chk("t1_rsp_lat", rsp_cyc[br] - acc_cyc[ba], 8);
    chk("t1_quo", rsp_q[br], 14);
    chk("t1_rem", rsp_r[br], 2);
    chk("t1_err", rsp_e[br], 0);

    // All four requesters valid straight out of reset.
    fix_lat = 3;
    set_reset(1'b0);
    push(0, 100, 7); push(1, 81, 9); push(2, 1000, 33); push(3, 7, 9);
    repeat (3) @(posedge clk);
    set_reset(1'b1);
    ba = acc_n; br = rsp_n;
    wait_idle("t2_drain", 200);
    for (int i = 0; i < 4; i++) begin
      chk("t2_gnt_order", acc_idx[ba + i], i);
      chk("t2_rsp_order", rsp_idx[br + i], i);
    end
    chk("t2_q0", rsp_q[br], 14);
    chk("t2_q1", rsp_q[br + 1], 9);
    chk("t2_q2", rsp_q[br + 2], 30);
    chk("t2_r2", rsp_r[br + 2], 10);
    chk("t2_r3", rsp_r[br + 3], 7);

    // Requesters 1 and 3 continuously valid with ptr at 2.
    push(1, 50, 5);
    wait_idle("t3_pre", 100);
    ba = acc_n;
    push(1, 11, 2); push(3, 12, 5); push(1, 13, 4); push(3, 14, 3);
    wait_idle("t3_drain", 200);
    chk("t3_g0", acc_idx[ba], 3);
    chk("t3_g1", acc_idx[ba + 1], 1);
    chk("t3_g2", acc_idx[ba + 2], 3);
    chk("t3_g3", acc_idx[ba + 3], 1);

    // Divider never completes.
    hang_mode = 1;
    ba = acc_n; br = rsp_n;
    push(0, 9, 3);
    wait_idle("t4_drain", TIMEOUT + 100);
    chk("t4_lat", rsp_cyc[br] - acc_cyc[ba], TIMEOUT + 2);
    chk("t4_err", rsp_e[br], 1);
    chk("t4_quo", rsp_q[br], 0);
    chk("t4_rem", rsp_r[br], 0);
    hang_mode = 0;

    // Reset while waiting on the divider; then ptr must restart at 0.
    push(1, 100, 10);
    wait_idle("t5_pre", 100);
    hang_mode = 1;
    ba = acc_n;
    push(2, 77, 7);
    b = 0;
    while (acc_n == ba && b < 20) begin @(negedge clk); b++; end
    chk("t5_acc", acc_n - ba, 1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    br = rsp_n;
    @(negedge clk);
    chk("t5_rst_rsp", bus.rsp_valid, 0);
    chk("t5_rst_start", bus.div_start, 0);
    chk("t5_rst_num", bus.div_numerador, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    hang_mode = 0;
    ba = acc_n;
    push(1, 20, 3); push(3, 21, 4);
    wait_idle("t5_drain", 200);
    chk("t5_first_gnt", acc_idx[ba], 1);
    chk("t5_nrsp", rsp_n - br, 2);

    // Zero denominator 55/0.
    ba = acc_n; bs = st_n; br = rsp_n;
    push(0, 55, 0);
    wait_idle("t6_drain", 100);
    chk("t6_quo", rsp_q[br], 32'hFFFF_FFFF);
    chk("t6_rem", rsp_r[br], 55);
`ifdef DIV_ARB_ZERO_BYPASS_EN
    chk("t6_nstart", st_n - bs, 0);
    chk("t6_lat", rsp_cyc[br] - acc_cyc[ba], 1);
    chk("t6_err", rsp_e[br], 1);
`else
    chk("t6_nstart", st_n - bs, 1);
    chk("t6_start_lat", st_cyc[bs] - acc_cyc[ba], 1);
    chk("t6_err", rsp_e[br], 0);
`endif

    // Randomized traffic against the reference model.
    fix_lat = 0; stale_rand = 1'b1; hang_mode = 2;
    for (int k = 0; k < 800; k++) begin
      @(posedge clk);
      #3;
      if ($urandom_range(0, 9) < 3) begin
        int r;
        r = int'($urandom_range(0, N - 1));
        if (qt[r] - qh[r] < 6)
          push(r, ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 5000)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 32'hFFFF_FFFF)) : 32'($urandom_range(1, 1000)));
      end
    end
    wait_idle("rand_drain", 20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one iterative divider among N requesters. Accepts one operand pair at a time and drives the divider's start/numerador/denominador. Captures cociente/resto on completion and returns them to the owning requester. Sits between requester blocks and the divider instance, connecting to the divider's DUV-side signals.

## Interface
- SIZE, 32, operand/result width
- N, 4, number of requesters (2..16)
- TIMEOUT, 256, max cycles waited for div_done before aborting
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N  request per requester; held until accepted
- req_num  in  N*SIZE  numerador of requester i at [i*SIZE +: SIZE]
- req_den  in  N*SIZE  denominador, same packing
- req_ready  out  N  one-hot accept pulse (1 cycle)
- rsp_valid  out  N  one-hot result pulse (1 cycle), no backpressure
- rsp_cociente  out  SIZE  quotient, valid with rsp_valid
- rsp_resto  out  SIZE  remainder, valid with rsp_valid
- rsp_err  out  1  timeout (or zero bypass, see Configuration), valid with rsp_valid
- div_start  out  1  start pulse to divider
- div_numerador, div_denominador  out  SIZE  operands, held stable IDLE-exit to RESP
- div_cociente, div_resto  in  SIZE  divider results
- div_done  in  1  divider completion

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant the first set bit scanning from ptr upward with wrap-around. Pulse req_ready[g], latch req_num/req_den slice g into div operands, store owner=g, go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle. Clear timeout counter. Go to WAIT.
- WAIT: completion is a rising edge of div_done (registered prior sample 0, current 1).
  - On completion: latch div_cociente/div_resto, rsp_err=0, go to RESP.
  - Counter reaching TIMEOUT before completion: results=0, rsp_err=1, go to RESP.
- RESP: rsp_valid[owner]=1 for one cycle. ptr <= (owner+1) mod N. Go to IDLE.
- Only one transaction in flight. req_valid changes outside IDLE are ignored until the next IDLE.
- Operands are sampled only in the accept cycle. Requester may change them afterward.
- Counter width is clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset (async assert): state=IDLE, ptr=0, owner=0. req_ready, rsp_valid, rsp_err, div_start = 0. div operands, rsp_cociente, rsp_resto = 0. done-edge register = 0.
- Reset mid-transaction aborts it silently: no rsp_valid, requester must reissue. Deassertion is taken synchronously to clk.
- Accept in cycle T; div_start in T+1; done edge observed at cycle D; rsp_valid at D+1.
  - Overhead is 3 cycles beyond divider latency.
  - Next accept no earlier than D+2.
- A done high during ISSUE or the first WAIT cycle without a 0 before it is not a completion. This covers stale done from a previous op.
- Fairness: the requester just served has lowest priority next round. Worst-case wait is N-1 transactions.

## Configuration
- DIV_ARB_ZERO_BYPASS_EN defined:
  - A request with denominador==0 goes IDLE->RESP directly with no div_start.
  - It returns cociente={SIZE{1'b1}}, resto=numerador, rsp_err=1.
  - rsp_valid arrives the cycle after accept.
- Undefined: zero denominators are issued to the divider like any other request. Result is whatever the divider returns, or a timeout.

## Test plan
- Single request, req 2: 100/7 -> div_start one cycle after req_ready[2]; rsp_valid[2] one cycle after done edge; cociente 14, resto 2, rsp_err 0.
- All 4 requesters valid simultaneously from reset -> grants in order 0,1,2,3. Each rsp_valid matches its own operands.
- Req 1 and req 3 continuously valid, ptr=2 -> grant order 3,1,3,1. No starvation.
- Divider stub never raises done -> rsp_valid[owner] with rsp_err=1 and zero results exactly TIMEOUT cycles after entering WAIT.
- rst_n asserted during WAIT -> all outputs 0 immediately, no response. After release, the next request is served from ptr=0.
- 55/0 with DIV_ARB_ZERO_BYPASS_EN -> no div_start; cociente 0xFFFFFFFF, resto 55, rsp_err 1, one cycle after accept. Without the macro -> the request is issued to the divider.
